// File: rtl/cpu_disp_pkg.sv
// Shared constants for the CPU debug display front panel: view count,
// seven-segment decode table and blank/off patterns.
package cpu_disp_pkg;

  localparam int VIEW_NUM = 8;
  localparam int VIEW_W   = 3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low key; pulses key_press for one
// cycle when the accepted level goes from released to pressed.
module key_debounce #(
  parameter int DEB_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_press
);

  localparam int CW = $clog2(DEB_CNT + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  assign accept    = (sync2_q != stable_q) && (cnt_q == CW'(DEB_CNT - 1));
  assign key_press = accept && stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_disp_ctrl.sv
// Front-panel controller: debounced keys step or auto-scroll the view select,
// and the selected 16-bit word is scanned onto a 4-digit seven-segment display.
module cpu_disp_ctrl
  import cpu_disp_pkg::*;
#(
  parameter int DEB_CNT  = 1_000_000,
  parameter int SCAN_CNT = 50_000,
  parameter int AUTO_CNT = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_next,
  input  logic              key_mode,
  input  logic [15:0]       dsp,
  output logic [VIEW_W-1:0] key_v,
  output logic              auto_mode,
  output logic [3:0]        seg_an,
  output logic [7:0]        seg_data
);

  localparam int AW = $clog2(AUTO_CNT + 1);
  localparam int SW = $clog2(SCAN_CNT + 1);

  logic next_ev, mode_ev;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_next (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_next),
    .key_press(next_ev)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_mode (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_mode),
    .key_press(mode_ev)
  );

  logic [VIEW_W-1:0] key_v_q, key_v_d;
  logic              auto_q, auto_d;
  logic [AW-1:0]     atmr_q, atmr_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [1:0]        sidx_q, sidx_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              auto_tick, step, scan_wrap;

  assign auto_tick = auto_q && (atmr_q == AW'(AUTO_CNT - 1));
  assign step      = next_ev || auto_tick;
  assign scan_wrap = (scnt_q == SW'(SCAN_CNT - 1));

  always_comb begin
    key_v_d = key_v_q;
    auto_d  = auto_q;
    atmr_d  = atmr_q;
    scnt_d  = scnt_q + 1'b1;
    sidx_d  = sidx_q;
    an_d    = ~(4'b0001 << sidx_q);
    seg_d   = SEG_HEX[dsp[{sidx_q, 2'b00} +: 4]];

    if (mode_ev) begin
      auto_d = ~auto_q;
    end

    // A key step or a mode toggle restarts the full auto interval.
    if (mode_ev || next_ev || auto_tick) begin
      atmr_d = '0;
    end else if (auto_q) begin
      atmr_d = atmr_q + 1'b1;
    end

    if (step) begin
      key_v_d = (key_v_q == VIEW_W'(VIEW_NUM - 1)) ? '0 : key_v_q + 1'b1;
    end

    if (scan_wrap) begin
      scnt_d = '0;
      sidx_d = sidx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_v_q <= '0;
      auto_q  <= 1'b0;
      atmr_q  <= '0;
      scnt_q  <= '0;
      sidx_q  <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      key_v_q <= key_v_d;
      auto_q  <= auto_d;
      atmr_q  <= atmr_d;
      scnt_q  <= scnt_d;
      sidx_q  <= sidx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign key_v     = key_v_q;
  assign auto_mode = auto_q;
  assign seg_an    = an_q;
  assign seg_data  = seg_q;

endmodule
